// File: rtl/hs_parallel_out_fifo.sv
// Handshake parallel output port: CPU pushes words into a small transmit FIFO,
// an output FSM drains it one word per dav_/rfd handshake.
module hs_parallel_out_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         s_,
    input  logic         ior_,
    input  logic         iow_,
    input  logic         a0,
    inout  wire  [W-1:0] d_bus,
    output logic         dav_,
    input  logic         rfd,
    output logic [W-1:0] byte_out,
    output logic         int_
);

    typedef enum logic [1:0] {IDLE, PRES, WAITLO, WAITHI} state_t;

    localparam logic [PTRW:0] FULL_CNT = (PTRW+1)'(DEPTH);

    state_t          state, state_nx;
    logic            dav_nx;
    logic [W-1:0]    mem [DEPTH];
    logic [PTRW-1:0] wptr, rptr;
    logic [PTRW:0]   count;
    logic            ie, ovr;
    logic            wr_data_q, wr_ctl_q, rd_sts_q;
    logic            wr_data, wr_ctl, rd_cnt, rd_sts;
    logic            wr_start, ctl_start, sts_end;
    logic            nf, empty, flush, pop, push, drop;
    logic [W-1:0]    rd_word;

    assign wr_data = ~s_ & ~iow_ &  ior_ & ~a0;
    assign wr_ctl  = ~s_ & ~iow_ &  ior_ &  a0;
    assign rd_cnt  = ~s_ & ~ior_ &  iow_ & ~a0;
    assign rd_sts  = ~s_ & ~ior_ &  iow_ &  a0;

    // One action per access: act on the leading edge of a write, trailing edge of a status read.
    assign wr_start  = wr_data & ~wr_data_q;
    assign ctl_start = wr_ctl  & ~wr_ctl_q;
    assign sts_end   = ~rd_sts &  rd_sts_q;

    assign nf    = (count != FULL_CNT);
    assign empty = (count == '0);
    assign flush = ctl_start & d_bus[1];
    assign push  = wr_start & (nf | pop);
    assign drop  = wr_start & ~push;
    assign int_  = ~(ie & nf);

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            wr_data_q <= 1'b0;
            wr_ctl_q  <= 1'b0;
            rd_sts_q  <= 1'b0;
        end else begin
            wr_data_q <= wr_data;
            wr_ctl_q  <= wr_ctl;
            rd_sts_q  <= rd_sts;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wptr] <= d_bus;
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ie    <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            if (ctl_start) ie <= d_bus[0];
            if (drop) ovr <= 1'b1;
            else if (sts_end) ovr <= 1'b0;
            if (flush) begin
                rptr  <= wptr;
                count <= '0;
            end else begin
                if (push) wptr <= wptr + 1'b1;
                if (pop)  rptr <= rptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // A flush in the same cycle suppresses the pop entirely, so the FSM stays in IDLE.
    always_comb begin
        state_nx = state;
        dav_nx   = dav_;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                dav_nx = 1'b1;
                if (!empty && rfd && !flush) begin
                    pop      = 1'b1;
                    state_nx = PRES;
                end
            end
            PRES: begin
                dav_nx   = 1'b0;
                state_nx = WAITLO;
            end
            WAITLO: begin
                if (!rfd) begin
                    dav_nx   = 1'b1;
                    state_nx = WAITHI;
                end
            end
            WAITHI: begin
                if (rfd) state_nx = IDLE;
            end
            default: begin
                dav_nx   = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state    <= IDLE;
            dav_     <= 1'b1;
            byte_out <= '0;
        end else begin
            state <= state_nx;
            dav_  <= dav_nx;
            if (pop) byte_out <= mem[rptr];
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_sts) rd_word[4:0] = {(state != IDLE), ie, ovr, empty, nf};
        else        rd_word[PTRW:0] = count;
    end

    assign d_bus = (rd_cnt | rd_sts) ? rd_word : 'z;

endmodule
